ibex_trace_buffer: RTL

IBEX_TRACE_BUFFER -- requirements
Module: ibex_trace_buffer

---
 rtl/ibex_pkg.sv | 27 ++
 rtl/ibex_trace_mem.sv | 27 ++
 rtl/ibex_trace_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction trace buffer: FSM state encoding,
// the captured retirement record and a small saturating-counter helper.
package ibex_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } trace_state_e;

   // One retired instruction as seen on RVFI (103 bits).
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        trap;
      logic        intr;
   } trace_rec_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ibex_trace_mem.sv
// Record storage for the trace buffer: Depth flop slots, one synchronous
// write port and one combinational read port. Contents are not reset.
module ibex_trace_mem
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 16
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(Depth)-1:0]   waddr_i,
   input  trace_rec_t                 wdata_i,
   input  logic [$clog2(Depth)-1:0]   raddr_i,
   output trace_rec_t                 rdata_o
);

   trace_rec_t mem_q [Depth];

   // Write one record per enabled cycle.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibex_trace_buffer.sv
// Circular trace buffer for retired instructions. After arming it records
// every retirement, keeping the newest Depth entries; a PC match or a trap
// fires the trigger, PostTrig further records are captured, and the frozen
// contents are then drained oldest-first through a valid/ready port.
module ibex_trace_buffer
   import ibex_pkg::*;
#(
   parameter int unsigned Depth      = 16,
   parameter int unsigned PostTrig   = 8,
   parameter bit          TrapTrigEn = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       arm_i,
   input  logic                       trig_pc_en_i,
   input  logic [31:0]                trig_pc_i,
   input  logic                       rvfi_valid_i,
   input  logic [31:0]                rvfi_pc_rdata_i,
   input  logic [31:0]                rvfi_insn_i,
   input  logic [4:0]                 rvfi_rd_addr_i,
   input  logic [31:0]                rvfi_rd_wdata_i,
   input  logic                       rvfi_trap_i,
   input  logic                       rvfi_intr_i,
   output logic                       rd_valid_o,
   input  logic                       rd_ready_i,
   output trace_rec_t                 rd_rec_o,
   output logic                       rd_last_o,
   output trace_state_e               state_o,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       trig_o,
   output logic [15:0]                dropped_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] Full = CW'(Depth);
   // Post-trigger counter value at which the last post-trigger record lands.
   localparam logic [AW-1:0] PostLast = AW'((PostTrig == 0) ? 0 : PostTrig - 1);

   if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("ibex_trace_buffer: Depth must be a power of two and at least 4");
   end
   if (PostTrig >= Depth) begin : g_bad_post
      $error("ibex_trace_buffer: PostTrig must be smaller than Depth");
   end

   trace_state_e  state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   dropped_q, dropped_d;
   logic [AW-1:0] post_q, post_d;
   logic          trig_q, trig_d;
   logic          mem_we;
   logic          trigger;
   trace_rec_t    wr_rec;

   assign wr_rec = '{
      pc:       rvfi_pc_rdata_i,
      insn:     rvfi_insn_i,
      rd_addr:  rvfi_rd_addr_i,
      rd_wdata: rvfi_rd_wdata_i,
      trap:     rvfi_trap_i,
      intr:     rvfi_intr_i
   };

   assign trigger = rvfi_valid_i &
                    ((trig_pc_en_i & (rvfi_pc_rdata_i == trig_pc_i)) |
                     (TrapTrigEn & rvfi_trap_i));

   // Next-state logic: arming wins over everything, then capture or readout.
   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      dropped_d = dropped_q;
      post_d    = post_q;
      trig_d    = 1'b0;
      mem_we    = 1'b0;

      if (arm_i) begin
         state_d   = ARMED;
         wptr_d    = '0;
         rptr_d    = '0;
         count_d   = '0;
         dropped_d = '0;
         post_d    = '0;
      end else begin
         unique case (state_q)
            ARMED, POST: begin
               if (rvfi_valid_i) begin
                  mem_we = 1'b1;
                  wptr_d = wptr_q + AW'(1);
                  // A full buffer drops its oldest entry to make room.
                  if (count_q == Full) begin
                     rptr_d    = rptr_q + AW'(1);
                     dropped_d = sat_inc16(dropped_q);
                  end else begin
                     count_d = count_q + CW'(1);
                  end
                  if (state_q == ARMED) begin
                     if (trigger) begin
                        trig_d  = 1'b1;
                        post_d  = '0;
                        state_d = (PostTrig == 0) ? DONE : POST;
                     end
                  end else begin
                     post_d = post_q + AW'(1);
                     if (post_q == PostLast) begin
                        state_d = DONE;
                     end
                  end
               end
            end
            DONE: begin
               if (count_q == '0) begin
                  state_d = IDLE;
               end else if (rd_ready_i) begin
                  rptr_d  = rptr_q + AW'(1);
                  count_d = count_q - CW'(1);
                  if (count_q == CW'(1)) begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               // IDLE: retirements are ignored until the next arm.
            end
         endcase
      end
   end

   // Control state registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         dropped_q <= '0;
         post_q    <= '0;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         dropped_q <= dropped_d;
         post_q    <= post_d;
         trig_q    <= trig_d;
      end
   end

   ibex_trace_mem #(
      .Depth (Depth)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (wptr_q),
      .wdata_i (wr_rec),
      .raddr_i (rptr_q),
      .rdata_o (rd_rec_o)
   );

   assign rd_valid_o = (state_q == DONE) && (count_q != '0);
   assign rd_last_o  = (count_q == CW'(1));
   assign state_o    = state_q;
   assign count_o    = count_q;
   assign trig_o     = trig_q;
   assign dropped_o  = dropped_q;

endmodule
